pmem_responder: RTL
===================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 10, cycles from request acceptance to resp; legal range 1-255.
REQ-002 Parameter DEPTH_LINES, default 256, number of 128-bit lines stored; power of two, 2-4096.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 read  input  1  line read request, held by the initiator until resp.
REQ-006 write  input  1  line write request, held by the initiator until resp.
REQ-007 address  input  16  byte address of the line.
REQ-008 wdata  input  128  write line data.
REQ-009 byte_enable  input  2  write enable per 64-bit half: bit0 = wdata[63:0], bit1 = wdata[127:64].
REQ-010 resp  output  1  one-cycle completion pulse for read or write.
REQ-011 rdata  output  128  read line data, valid in the resp cycle.
REQ-012 busy  output  1  high while a request is accepted and not yet completed.
REQ-013 conflict  output  1  sticky flag: read and write sampled high together at acceptance.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 IDLE: on an edge with read or write high, the block SHALL latch the operation, line index, wdata and byte_enable, load the counter with LATENCY-1, and go to BUSY.
REQ-016 Line index SHALL be address[4+log2(DEPTH_LINES)-1:4]; address[3:0] and upper bits ignored (aliasing allowed).
REQ-017 Read and write both high at acceptance: the block SHALL perform the write only and set conflict.
REQ-018 BUSY: the counter SHALL decrement each edge; on the edge where it is 0, the block SHALL go to RESP and assert resp.
REQ-019 resp SHALL rise exactly LATENCY edges after the acceptance edge and stay high exactly one cycle.
REQ-020 On the edge entering RESP, a read SHALL register the addressed line into rdata; a write SHALL update the enabled 64-bit halves of the line.
REQ-021 rdata SHALL hold its value until the next read completion; writes SHALL NOT change rdata.
REQ-022 RESP SHALL return to IDLE unconditionally, ignoring read/write on that edge.
REQ-023 The next acceptance SHALL occur no earlier than the edge after the RESP->IDLE edge.
REQ-024 Input changes after acceptance SHALL be ignored until the next acceptance.
REQ-025 busy SHALL be high in BUSY and RESP, low in IDLE.
REQ-026 byte_enable = 2'b00 write SHALL complete with resp and leave memory unchanged.
REQ-027 Storage SHALL be DEPTH_LINES x 128-bit registers or inferred RAM, with read-after-write coherent: a read accepted after a write's resp SHALL return the written data.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, resp 0, busy 0, conflict 0, rdata 0.
REQ-029 Reset during BUSY SHALL abort the request: no resp, no memory update.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 The first acceptance SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-032 LATENCY=10: write address 16'h0040, wdata all 16'hA5A5 pattern, byte_enable 2'b11 -> resp 10 edges later for 1 cycle; read 16'h0040 -> rdata = written pattern in the resp cycle.
REQ-033 Line 16'h0080 holds 128'h1111...1111; write 128'h2222...2222 with byte_enable 2'b10 -> subsequent read returns 128'h2222...2222_1111...1111 (high half new).
REQ-034 Read held high through resp and one extra cycle -> exactly one resp pulse; no second acceptance until the edge after the RESP->IDLE edge.
REQ-035 Read and write both high at 16'h0100, byte_enable 2'b11 -> write performed, conflict = 1 until reset, rdata unchanged.
REQ-036 rst_n low 4 cycles after accepting a write to 16'h0200 -> no resp, busy 0 immediately, later read of 16'h0200 returns the pre-write contents.
REQ-037 LATENCY=1: read accepted -> resp on the next edge; DEPTH_LINES=256, address 16'h1040 aliases 16'h0040.

Source files
------------

// File: rtl/pmem_responder.sv
// pmem_responder: line-oriented memory model that answers each read or write
// request with a single resp pulse a fixed LATENCY cycles after acceptance.
//
// Ports
//   clk          single clock, all state on rising edge
//   rst_n        asynchronous active-low reset (memory contents are kept)
//   read         line read request, held by the initiator until resp
//   write        line write request, held by the initiator until resp
//   address      byte address; bits [4 +: log2(DEPTH_LINES)] select the line
//   wdata        128-bit write line data
//   byte_enable  per-64-bit-half write enable (bit0 = low half)
//   resp         one-cycle completion pulse
//   rdata        read line data, updated only when a read completes
//   busy         high from acceptance until the RESP->IDLE edge
//   conflict     sticky: read and write were both high at an acceptance
module pmem_responder #(
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         read,
    input  logic         write,
    input  logic [15:0]  address,
    input  logic [127:0] wdata,
    input  logic [1:0]   byte_enable,
    output logic         resp,
    output logic [127:0] rdata,
    output logic         busy,
    output logic         conflict
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned HALF_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              op_write;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic [1:0]        be_q;

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    logic accept_c;
    logic done_c;

    // Address bits outside the line index are intentionally ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^address;

    assign accept_c = (state == ST_IDLE) && (read || write);
    assign done_c   = (state == ST_BUSY) && (cnt == '0);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (read || write) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == '0)     state_nxt = ST_RESP;
            ST_RESP:                    state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture, latency counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            resp     <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            rdata    <= '0;
        end else begin
            resp <= (state_nxt == ST_RESP);
            busy <= (state_nxt != ST_IDLE);
            if (accept_c) begin
                cnt      <= CNT_W'(LATENCY - 1);
                // A simultaneous read+write is treated as a write only.
                op_write <= write;
                idx_q    <= address[4 +: IDX_W];
                wdata_q  <= wdata;
                be_q     <= byte_enable;
                if (read && write) begin
                    conflict <= 1'b1;
                end
            end else if ((state == ST_BUSY) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done_c && !op_write) begin
                rdata <= mem[idx_q];
            end
        end
    end

    // Line storage; not reset. Reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (done_c && op_write) begin
            if (be_q[0]) mem[idx_q][HALF_W-1:0]      <= wdata_q[HALF_W-1:0];
            if (be_q[1]) mem[idx_q][LINE_W-1:HALF_W] <= wdata_q[LINE_W-1:HALF_W];
        end
    end

endmodule
